// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Multi-channel push-button / switch input conditioner. Each channel passes
// through a 2-FF synchronizer and a counter-based debounce filter. One-cycle
// press/release pulses mark every debounced transition. The block sits in
// front of the core on board top levels and produces clean reset/halt levels.
//
// Parameters:
//   CLOCK_FREQUENCY  clock frequency in Hz
//   DEBOUNCE_US      required stable time in microseconds
//   NUM_INPUTS       number of independent channels
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low reset; clears every flop
//   button_in      raw asynchronous button/switch levels
//   button_out     debounced stable levels (active-high "pressed")
//   press_pulse    1-cycle pulse after a debounced 0->1 transition
//   release_pulse  1-cycle pulse after a debounced 1->0 transition
//
// Build option:
//   BUTTON_CONDITIONER_ACTIVE_LOW_EN - when defined, button_in is inverted
//   at the first synchronizer flop, for boards with active-low buttons. The
//   outputs keep their active-high meaning. Reset values are 0 in both
//   builds, so an idle-high button reads as released after reset, with no
//   pulse.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DEBOUNCE_US     = 10000,
  parameter int NUM_INPUTS      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] button_in,
  output logic [NUM_INPUTS-1:0] button_out,
  output logic [NUM_INPUTS-1:0] press_pulse,
  output logic [NUM_INPUTS-1:0] release_pulse
);

  // Number of consecutive mismatching samples needed before the output moves.
  // A value of 1 means the output simply follows the synchronizer.
  localparam int DEBOUNCE_RAW    = (CLOCK_FREQUENCY / 32'sd1000000) * DEBOUNCE_US;
  localparam int DEBOUNCE_CYCLES = (DEBOUNCE_RAW < 32'sd1) ? 32'sd1 : DEBOUNCE_RAW;
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 32'sd1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  // The counter saturates here and never wraps.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);

  logic [NUM_INPUTS-1:0] raw_s;
  logic [NUM_INPUTS-1:0] sync1_r;
  logic [NUM_INPUTS-1:0] sync2_r;
  logic [CNT_W-1:0]      count_r      [NUM_INPUTS];
  logic [CNT_W-1:0]      count_nxt_s  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] out_r;
  logic [NUM_INPUTS-1:0] out_nxt_s;
  logic [NUM_INPUTS-1:0] press_r;
  logic [NUM_INPUTS-1:0] press_nxt_s;
  logic [NUM_INPUTS-1:0] release_r;
  logic [NUM_INPUTS-1:0] release_nxt_s;

`ifdef BUTTON_CONDITIONER_ACTIVE_LOW_EN
  // Active-low board buttons: fold the inversion into the first sync stage.
  assign raw_s = ~button_in;
`else
  assign raw_s = button_in;
`endif

  // Per-channel debounce decision: restart on agreement, commit on the
  // DEBOUNCE_CYCLES-th consecutive disagreement, otherwise keep counting.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      count_nxt_s[i]   = count_r[i];
      out_nxt_s[i]     = out_r[i];
      press_nxt_s[i]   = 1'b0;
      release_nxt_s[i] = 1'b0;
      if (sync2_r[i] == out_r[i]) begin
        count_nxt_s[i] = CNT_ZERO;
      end else if (count_r[i] == CNT_MAX) begin
        // Pulse is registered on the same edge as the level change, so it
        // is visible exactly during the cycle following that edge.
        count_nxt_s[i]   = CNT_ZERO;
        out_nxt_s[i]     = sync2_r[i];
        press_nxt_s[i]   = sync2_r[i];
        release_nxt_s[i] = ~sync2_r[i];
      end else begin
        count_nxt_s[i] = count_r[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer, counters, debounced levels and pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r   <= {NUM_INPUTS{1'b0}};
      sync2_r   <= {NUM_INPUTS{1'b0}};
      out_r     <= {NUM_INPUTS{1'b0}};
      press_r   <= {NUM_INPUTS{1'b0}};
      release_r <= {NUM_INPUTS{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
        count_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      out_r     <= out_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        count_r[i] <= count_nxt_s[i];
      end
    end
  end

  assign button_out    = out_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clock;
  logic       reset;
  logic [1:0] button_in;
  logic [1:0] button_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int n_checks;
  int n_pass;

  button_conditioner #(
    .CLOCK_FREQUENCY(1000000),
    .DEBOUNCE_US    (4),
    .NUM_INPUTS     (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_in    (button_in),
    .button_out   (button_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Map a "pressed" pattern to the raw board level for this build.
  function automatic logic [1:0] to_raw(input logic [1:0] pressed);
`ifdef BUTTON_CONDITIONER_ACTIVE_LOW_EN
    return ~pressed;
`else
    return pressed;
`endif
  endfunction

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int n_press;
  int n_rel;
  int seen_out;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    button_in = to_raw(2'b11);

    // ---- reset with both buttons held ----
    repeat (5) tick();
    check_eq("rst_out", int'(button_out), 0);
    check_eq("rst_press", int'(press_pulse), 0);
    check_eq("rst_rel", int'(release_pulse), 0);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("rst_hold_out", int'(button_out), 0);
    end
    tick();
    check_eq("rst_edge6_out", int'(button_out), 3);
    check_eq("rst_edge6_press", int'(press_pulse), 3);
    check_eq("rst_edge6_rel", int'(release_pulse), 0);
    tick();
    check_eq("rst_edge7_press", int'(press_pulse), 0);
    check_eq("rst_edge7_out", int'(button_out), 3);

    // back to idle: both release together
    button_in = to_raw(2'b00);
    repeat (5) tick();
    check_eq("idle_edge5_out", int'(button_out), 3);
    tick();
    check_eq("idle_edge6_out", int'(button_out), 0);
    check_eq("idle_edge6_rel", int'(release_pulse), 3);
    check_eq("idle_edge6_press", int'(press_pulse), 0);
    tick();
    check_eq("idle_edge7_rel", int'(release_pulse), 0);

    // ---- clean press on channel 0 ----
    button_in = to_raw(2'b01);
    repeat (5) tick();
    check_eq("clean_edge5_out", int'(button_out), 0);
    check_eq("clean_edge5_press", int'(press_pulse), 0);
    tick();
    check_eq("clean_edge6_out", int'(button_out), 1);
    check_eq("clean_edge6_press", int'(press_pulse), 1);
    tick();
    check_eq("clean_edge7_press", int'(press_pulse), 0);
    check_eq("clean_edge7_out", int'(button_out), 1);
    button_in = to_raw(2'b00);
    repeat (6) tick();
    check_eq("clean_rel_out", int'(button_out), 0);
    check_eq("clean_rel_pulse", int'(release_pulse), 1);
    tick();
    check_eq("clean_rel_after", int'(release_pulse), 0);

    // ---- 3-cycle glitch: rejected ----
    n_press  = 0;
    n_rel    = 0;
    seen_out = 0;
    for (int k = 0; k < 13; k++) begin
      button_in = (k < 3) ? to_raw(2'b01) : to_raw(2'b00);
      tick();
      n_press  += int'(press_pulse[0]) + int'(press_pulse[1]);
      n_rel    += int'(release_pulse[0]) + int'(release_pulse[1]);
      seen_out |= int'(button_out);
    end
    check_eq("glitch3_out_seen", seen_out, 0);
    check_eq("glitch3_press", n_press, 0);
    check_eq("glitch3_rel", n_rel, 0);

    // ---- 4-cycle pulse: passes, then releases ----
    n_press = 0;
    n_rel   = 0;
    for (int k = 0; k < 14; k++) begin
      button_in = (k < 4) ? to_raw(2'b01) : to_raw(2'b00);
      tick();
      n_press += int'(press_pulse[0]) + int'(press_pulse[1]);
      n_rel   += int'(release_pulse[0]) + int'(release_pulse[1]);
      if (k == 4) check_eq("pulse4_edge5_out", int'(button_out), 0);
      if (k == 5) check_eq("pulse4_edge6_press", int'(press_pulse), 1);
      if (k == 9) check_eq("pulse4_rel_edge", int'(release_pulse), 1);
    end
    check_eq("pulse4_press_cnt", n_press, 1);
    check_eq("pulse4_rel_cnt", n_rel, 1);
    check_eq("pulse4_final_out", int'(button_out), 0);

    // ---- bounce on channel 1: 1,0,1,0 then hold 1 ----
    n_press = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 4) button_in = to_raw((k % 2 == 0) ? 2'b10 : 2'b00);
      else       button_in = to_raw(2'b10);
      tick();
      n_press += int'(press_pulse[0]) + int'(press_pulse[1]);
      if (k == 8) check_eq("bounce_edge5_out", int'(button_out), 0);
      if (k == 9) check_eq("bounce_edge6_press", int'(press_pulse), 2);
    end
    check_eq("bounce_press_cnt", n_press, 1);
    check_eq("bounce_out", int'(button_out), 2);
    n_rel = 0;
    button_in = to_raw(2'b00);
    for (int k = 0; k < 10; k++) begin
      tick();
      n_rel += int'(release_pulse[0]) + int'(release_pulse[1]);
    end
    check_eq("bounce_rel_cnt", n_rel, 1);
    check_eq("bounce_rel_out", int'(button_out), 0);

    // ---- async reset mid-count ----
    button_in = to_raw(2'b01);
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_mid_out", int'(button_out), 0);
    check_eq("arst_mid_press", int'(press_pulse), 0);
    tick();
    tick();
    check_eq("arst_mid_held", int'(button_out), 0);
    reset = 1'b1;
    n_press = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_press += int'(press_pulse[0]) + int'(press_pulse[1]);
      if (k == 4) check_eq("arst_mid_edge5_out", int'(button_out), 0);
    end
    check_eq("arst_mid_edge6_out", int'(button_out), 1);
    check_eq("arst_mid_edge6_press", int'(press_pulse), 1);
    check_eq("arst_mid_press_cnt", n_press, 1);

    // ---- async reset with output high and pulse live: clears between edges ----
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_hi_out", int'(button_out), 0);
    check_eq("arst_hi_press", int'(press_pulse), 0);
    check_eq("arst_hi_rel", int'(release_pulse), 0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check_eq("arst_hi_edge5_out", int'(button_out), 0);
    tick();
    check_eq("arst_hi_edge6_out", int'(button_out), 1);
    check_eq("arst_hi_edge6_press", int'(press_pulse), 1);
    button_in = to_raw(2'b00);
    repeat (6) tick();
    check_eq("arst_hi_rel_pulse", int'(release_pulse), 1);
    tick();

`ifdef BUTTON_CONDITIONER_ACTIVE_LOW_EN
    // ---- active-low build: idle-high buttons read released ----
    reset     = 1'b0;
    button_in = 2'b11;
    repeat (2) tick();
    reset    = 1'b1;
    seen_out = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen_out |= int'(button_out) | int'(press_pulse) | int'(release_pulse);
    end
    check_eq("al_idle_quiet", seen_out, 0);
    button_in = 2'b10;
    repeat (5) tick();
    check_eq("al_edge5_out", int'(button_out), 0);
    tick();
    check_eq("al_edge6_out", int'(button_out), 1);
    check_eq("al_edge6_press", int'(press_pulse), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel push-button/switch input conditioner for the board top-level wrappers.
- Sits directly upstream of the rvx instance. Produces the clean `reset`/`halt` levels (and optional edge pulses) from raw board buttons.
- Per channel: 2-FF synchronizer, then counter-based debounce. Replaces the single-register sampling currently used on board tops.

Parameters:
- CLOCK_FREQUENCY, 50000000, clock frequency in Hz.
- DEBOUNCE_US, 10000, required stable time in microseconds.
- NUM_INPUTS, 2, number of independent channels.
- Derived DEBOUNCE_CYCLES = CLOCK_FREQUENCY/1000000*DEBOUNCE_US, clamped to a minimum of 1.
- Counter width = $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clock  input  1  system clock (the divided core clock on board tops).
- reset  input  1  asynchronous, active-low reset.
- button_in  input  NUM_INPUTS  raw asynchronous button/switch levels.
- button_out  output  NUM_INPUTS  debounced stable levels.
- press_pulse  output  NUM_INPUTS  1-cycle pulse on a debounced 0->1 transition.
- release_pulse  output  NUM_INPUTS  1-cycle pulse on a debounced 1->0 transition.

Behaviour:
- Reset: reset low immediately clears every flop, independent of clock.
  - Cleared flops: sync stages, counters, button_out, press_pulse, release_pulse (all 0).
  - Deassertion takes effect at the next clock edge.
- Synchronizer: sync1 <= button_in; sync2 <= sync1 (per bit, every edge).
- Debounce, per channel, evaluated every edge:
  - If sync2 == button_out: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: button_out <= sync2 and count <= 0.
  - Else: count <= count + 1.
- Latency: a clean input change present before edge 1 reaches button_out at edge 2+DEBOUNCE_CYCLES.
  - Edges 1–2 fill the synchronizer.
  - DEBOUNCE_CYCLES consecutive mismatching edges are then required.
- Glitch rejection:
  - Any sync2 sample equal to button_out restarts the count from 0.
  - Pulses shorter than DEBOUNCE_CYCLES cycles (after sync) never propagate.
- Pulses:
  - press_pulse[i] is high for exactly the one cycle following the edge where button_out[i] goes 0->1.
  - release_pulse[i] behaves the same for 1->0.
  - press_pulse and release_pulse are never both high on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- DEBOUNCE_CYCLES == 1: output follows sync2 with one extra cycle, i.e. no filtering beyond the synchronizer.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.
- Reset asserted mid-count:
  - count and button_out return to 0, and no pulse is emitted.
  - A button held through reset is re-debounced after release, giving a press_pulse.

Optional Feature:
- Macro BUTTON_CONDITIONER_ACTIVE_LOW_EN.
- Defined: button_in is inverted at the first synchronizer flop (for boards with active-low buttons). button_out, press_pulse and release_pulse keep active-high "pressed" meaning.
- Not defined: button_in is used as-is.
- Reset values are 0 in both builds. With the macro, a button idle-high at reset therefore reads as released with no pulse.

Test Plan:
- Config: CLOCK_FREQUENCY=1000000, DEBOUNCE_US=4 (DEBOUNCE_CYCLES=4), NUM_INPUTS=2, macro undefined unless stated.
- Reset: hold reset=0 with button_in=2'b11 for 5 cycles -> all outputs 0. Release reset -> button_out=2'b11 at the 6th edge, press_pulse=2'b11 for exactly one cycle.
- Clean press: button_in[0] 0->1 before edge 1 -> button_out[0]=1 after edge 6 (not after 5), press_pulse[0]=1 only in the cycle after edge 6, button_out[1] stays 0.
- Glitch: button_in[0]=1 for 3 cycles then 0 -> button_out[0] stays 0, no pulses. Repeat with 4 cycles -> button_out[0]=1 and one press_pulse.
- Bounce: toggle button_in[1] 1,0,1,0,1 each cycle, then hold 1 -> exactly one press_pulse[1], 6 edges after the final 0->1. Later release -> exactly one release_pulse[1].
- Async reset mid-count: press, drive reset=0 after edge 4 (between clock edges) -> outputs 0 immediately, no pulse. Release with the button held -> press after 6 more edges.
- Macro defined: button_in=2'b11 idle -> button_out=0. Drive button_in[0]=0 -> button_out[0]=1 after 6 edges, with a press_pulse.
